mmio_responder: RTL and testbench
=================================

// Module: mmio_responder
// PURPOSE
//  Data-bus responder for the single-cycle MIPS core's memwrite/dataadr/writedata/readdata port; replaces the bare data memory.
//  Decodes each access to one of three targets: an internal word RAM, an LED/switch I/O block, or a compare-match timer.
//  The timer can raise a level interrupt. Data-bus reads are combinational; every register update occurs on the rising clock edge.
// PARAMETERS
//  RAM_WORDS     64   depth of internal word RAM (power of 2); occupies byte addresses 0 .. RAM_WORDS*4-1
//  PRESCALE_DIV  4    timer ticks once every PRESCALE_DIV clk cycles (>=1)
// PORTS
//  clk        in   1   system clock; all state updates on posedge
//  reset      in   1   synchronous, active-low reset
//  memwrite   in   1   write strobe from core; 1 = write writedata to dataadr this cycle
//  dataadr    in   32  byte address from core
//  writedata  in   32  write data from core
//  readdata   out  32  read data to core, combinational from dataadr
//  switches   in   16  asynchronous board switches
//  leds       out  16  LED register output
//  irq        out  1   timer interrupt, level: STATUS.match & CTRL.irq_en
// BEHAVIOUR
//  Address map (word aligned; dataadr[1:0] ignored unless MMIO_ALIGN_CHECK_EN):
//   0x0000_0000+  RAM     RW; index dataadr[log2(RAM_WORDS)+1:2]; sync write, comb read; contents not reset
//   0xFFFF_FF00   LED     RW; bits[15:0], upper bits read 0
//   0xFFFF_FF04   SW      RO; switches through a 2-flop synchroniser, so readback lags a switch change by 2 cycles
//   0xFFFF_FF08   COUNT   RW; a write loads COUNT
//   0xFFFF_FF0C   CMP     RW
//   0xFFFF_FF10   CTRL    RW; bit0 en, bit1 auto_reload, bit2 irq_en
//   0xFFFF_FF14   STATUS  bit0 match, bit1 misalign; write-1-to-clear
//   Any other address: read 0, write ignored. Writes to SW are ignored.
//  Reset (reset==0 at posedge): LED=0, COUNT=0, CMP=0xFFFF_FFFF, CTRL=0, STATUS=0, prescaler=0, timer FSM=IDLE.
//   While reset is low: readdata=0, irq=0.
//  Timer FSM:
//   IDLE -> RUN when CTRL.en=1. RUN -> IDLE when CTRL.en=0. HOLD -> IDLE when CTRL.en=0.
//   In RUN the prescaler counts 0..PRESCALE_DIV-1. At the wrap cycle (tick), COUNT <= COUNT+1 (mod 2^32).
//   If the pre-increment COUNT==CMP on a tick:
//    - STATUS.match is set;
//    - with auto_reload=1, COUNT <= 0 and the FSM stays in RUN;
//    - otherwise COUNT holds and the FSM goes to HOLD (no further ticks).
//   The prescaler clears on entering RUN and on any write to COUNT.
//  Simultaneous events:
//   - A core write to COUNT in the same cycle as a tick: the write wins, and no match is evaluated that cycle.
//   - A match set and a W1C of STATUS.match in the same cycle: set wins, so match stays 1.
//   - A write to CTRL takes effect for FSM transitions on the next cycle.
//  irq is combinational from the registered flags. It asserts the cycle after the match edge and holds until cleared.
//  Reset asserted mid-count: state returns to reset values at that edge. No partial write occurs.
// CONFIGURATION
//  MMIO_ALIGN_CHECK_EN defined:
//   - Any access with dataadr[1:0]!=0 reads 0.
//   - If memwrite=1, the write is suppressed and STATUS.misalign is set (sticky until W1C).
//  MMIO_ALIGN_CHECK_EN undefined:
//   - dataadr[1:0] is ignored.
//   - STATUS.misalign always reads 0.
// TESTING
//  1. Write RAM[0x10]=0x1234_5678, then read 0x10 -> readdata=0x1234_5678 same cycle. Read 0xFFFF_FF20 -> 0.
//  2. Write LED=0xA5A5 -> leds=0xA5A5 next cycle. Set switches=0x00F0 -> SW read=0x00F0 after 2 cycles.
//  3. Load COUNT=0, CMP=3, CTRL=0x5, PRESCALE_DIV=4:
//     -> match and irq rise on the tick where COUNT==3. FSM goes to HOLD with COUNT=3.
//     -> Write STATUS=1 -> irq=0.
//  4. CTRL=0x7, CMP=1: COUNT sequence 0,1,0,1... on ticks; match re-sets each time.
//     -> W1C issued on a match cycle leaves match=1.
//  5. Write COUNT=0x100 on a tick cycle -> COUNT=0x100 and no increment. Assert reset mid-run -> all registers return to reset values, irq=0.
//  6. (MMIO_ALIGN_CHECK_EN) Write 0x0000_0012 -> RAM unchanged and STATUS=0x2. Without the macro -> RAM[0x10] written.

Source files
------------

// File: rtl/mmio_responder.sv
// mmio_responder: data-bus responder with a word RAM, LED/switch I/O and a compare-match timer.
// Optional build define MMIO_ALIGN_CHECK_EN: misaligned accesses read 0, drop writes and flag STATUS.misalign.
module mmio_responder #(
  parameter int RAM_WORDS    = 64,
  parameter int PRESCALE_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [15:0] switches,
  output logic [15:0] leds,
  output logic        irq
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} tstate_t;

  tstate_t        state_r;
  logic [PW-1:0]  pre_r;
  logic [31:0]    count_r, cmp_r;
  logic           en_r, auto_r, irq_en_r, match_r;
  logic [15:0]    led_r, sw_meta_r, sw_sync_r;
  logic [31:0]    ram_r [RAM_WORDS];
  logic [31:0]    rdata_s;

  logic [AW-1:0]  ram_idx_s;
  logic [5:0]     reg_sel_s;
  logic           ram_hit_s, io_page_s, aligned_s, wr_ok_s, wr_io_s;
  logic           cnt_wr_s, stat_wr_s, tick_s, hit_s, misalign_s;

  assign ram_idx_s = dataadr[AW+1:2];
  assign reg_sel_s = dataadr[7:2];
  assign ram_hit_s = (dataadr[31:AW+2] == {(30-AW){1'b0}});
  assign io_page_s = (dataadr[31:8] == 24'hFF_FFFF);

`ifdef MMIO_ALIGN_CHECK_EN
  logic misalign_r;
  assign aligned_s  = (dataadr[1:0] == 2'b00);
  assign misalign_s = misalign_r;

  // Sticky misalign flag; a misaligned write can never also be a STATUS write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      misalign_r <= 1'b0;
    end else if (memwrite && !aligned_s) begin
      misalign_r <= 1'b1;
    end else if (stat_wr_s && writedata[1]) begin
      misalign_r <= 1'b0;
    end
  end
`else
  logic unused_s;
  assign aligned_s  = 1'b1;
  assign misalign_s = 1'b0;
  assign unused_s   = ^dataadr[1:0];
`endif

  assign wr_ok_s   = memwrite & reset & aligned_s;
  assign wr_io_s   = wr_ok_s & io_page_s;
  assign cnt_wr_s  = wr_io_s & (reg_sel_s == 6'd2);
  assign stat_wr_s = wr_io_s & (reg_sel_s == 6'd5);
  assign tick_s    = (state_r == RUN) & en_r & (pre_r == PRE_LAST);
  assign hit_s     = tick_s & ~cnt_wr_s & (count_r == cmp_r);

  // Word RAM: synchronous write, contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s && ram_hit_s) begin
      ram_r[ram_idx_s] <= writedata;
    end
  end

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clk) begin
    sw_meta_r <= switches;
    sw_sync_r <= sw_meta_r;
  end

  // Core-writable LED, compare and control registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      led_r    <= 16'd0;
      cmp_r    <= 32'hFFFF_FFFF;
      en_r     <= 1'b0;
      auto_r   <= 1'b0;
      irq_en_r <= 1'b0;
    end else begin
      if (wr_io_s && reg_sel_s == 6'd0) led_r <= writedata[15:0];
      if (wr_io_s && reg_sel_s == 6'd3) cmp_r <= writedata;
      if (wr_io_s && reg_sel_s == 6'd4) begin
        en_r     <= writedata[0];
        auto_r   <= writedata[1];
        irq_en_r <= writedata[2];
      end
    end
  end

  // Timer FSM with prescaler, COUNT and the match flag; a core COUNT write overrides the tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      pre_r   <= {PW{1'b0}};
      count_r <= 32'd0;
      match_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (en_r) begin
            state_r <= RUN;
            pre_r   <= {PW{1'b0}};
          end
        end
        RUN: begin
          if (!en_r) begin
            state_r <= IDLE;
          end else if (pre_r != PRE_LAST) begin
            pre_r <= pre_r + PW'(1);
          end else begin
            pre_r <= {PW{1'b0}};
            if (hit_s) begin
              if (auto_r) count_r <= 32'd0;
              else        state_r <= HOLD;
            end else if (!cnt_wr_s) begin
              count_r <= count_r + 32'd1;
            end
          end
        end
        HOLD: begin
          if (!en_r) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
      if (cnt_wr_s) begin
        count_r <= writedata;
        pre_r   <= {PW{1'b0}};
      end
      if (hit_s) begin
        match_r <= 1'b1;
      end else if (stat_wr_s && writedata[0]) begin
        match_r <= 1'b0;
      end
    end
  end

  // Combinational read mux; everything reads 0 in reset or on a rejected access.
  always_comb begin
    rdata_s = 32'd0;
    if (!reset || !aligned_s) begin
      rdata_s = 32'd0;
    end else if (ram_hit_s) begin
      rdata_s = ram_r[ram_idx_s];
    end else if (io_page_s) begin
      case (reg_sel_s)
        6'd0:    rdata_s = {16'd0, led_r};
        6'd1:    rdata_s = {16'd0, sw_sync_r};
        6'd2:    rdata_s = count_r;
        6'd3:    rdata_s = cmp_r;
        6'd4:    rdata_s = {29'd0, irq_en_r, auto_r, en_r};
        6'd5:    rdata_s = {30'd0, misalign_s, match_r};
        default: rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign readdata = rdata_s;
  assign leds     = led_r;
  assign irq      = reset & match_r & irq_en_r;
endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed + randomized bench; a behavioural model is compared every cycle.
module tb_mmio_responder;
  localparam int RAM_WORDS = 64;
  localparam int DIV       = 4;
`ifdef MMIO_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam logic [31:0] A_LED = 32'hFFFF_FF00, A_SW = 32'hFFFF_FF04, A_CNT = 32'hFFFF_FF08;
  localparam logic [31:0] A_CMP = 32'hFFFF_FF0C, A_CTRL = 32'hFFFF_FF10, A_STAT = 32'hFFFF_FF14;

  logic        clk = 1'b0;
  logic        reset, memwrite, irq;
  logic [31:0] dataadr, writedata, readdata;
  logic [15:0] switches, leds;

  always #5 clk = ~clk;

  mmio_responder #(.RAM_WORDS(RAM_WORDS), .PRESCALE_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .readdata(readdata), .switches(switches),
    .leds(leds), .irq(irq)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Behavioural model state (register values as seen after the latest clock edge).
  logic [31:0] m_ram [RAM_WORDS];
  logic [15:0] m_leds = 16'd0, m_sw1 = 16'd0, m_sw2 = 16'd0;
  logic [31:0] m_count, m_cmp;
  bit          m_en, m_auto, m_irqen, m_match, m_mis, m_running, m_held;
  int          m_age;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic rst, input logic [31:0] a);
    if (!rst) return 32'd0;
    if (ALIGN && a[1:0] != 2'b00) return 32'd0;
    if (a < RAM_WORDS * 4) return m_ram[a[7:2]];
    if (a[31:8] != 24'hFF_FFFF) return 32'd0;
    case (a[7:2])
      6'd0:    return {16'd0, m_leds};
      6'd1:    return {16'd0, m_sw2};
      6'd2:    return m_count;
      6'd3:    return m_cmp;
      6'd4:    return {29'd0, m_irqen, m_auto, m_en};
      6'd5:    return {30'd0, m_mis, m_match};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_irq();
    return reset && m_match && m_irqen;
  endfunction

  task automatic m_edge(input logic rst, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [15:0] sw);
    bit ok, io, cnt_wr, stat_wr, set_match;
    logic [5:0] r;
    m_sw2 = m_sw1;
    m_sw1 = sw;
    if (!rst) begin
      m_leds = 16'd0; m_count = 32'd0; m_cmp = 32'hFFFF_FFFF;
      m_en = 1'b0; m_auto = 1'b0; m_irqen = 1'b0; m_match = 1'b0; m_mis = 1'b0;
      m_running = 1'b0; m_held = 1'b0; m_age = 0;
      return;
    end
    ok        = we && !(ALIGN && a[1:0] != 2'b00);
    io        = ok && (a[31:8] == 24'hFF_FFFF);
    r         = a[7:2];
    cnt_wr    = io && r == 6'd2;
    stat_wr   = io && r == 6'd5;
    set_match = 1'b0;
    if (m_running) begin
      if (!m_en) m_running = 1'b0;
      else if (m_age + 1 == DIV) begin
        m_age = 0;
        if (!cnt_wr) begin
          if (m_count == m_cmp) begin
            set_match = 1'b1;
            if (m_auto) m_count = 32'd0;
            else begin m_running = 1'b0; m_held = 1'b1; end
          end else m_count = m_count + 32'd1;
        end
      end else m_age++;
    end else if (m_held) begin
      if (!m_en) m_held = 1'b0;
    end else if (m_en) begin
      m_running = 1'b1;
      m_age     = 0;
    end
    if (cnt_wr) begin m_count = wd; m_age = 0; end
    if (set_match) m_match = 1'b1;
    else if (stat_wr && wd[0]) m_match = 1'b0;
    if (ALIGN && we && a[1:0] != 2'b00) m_mis = 1'b1;
    else if (stat_wr && wd[1]) m_mis = 1'b0;
    if (io && r == 6'd0) m_leds = wd[15:0];
    if (io && r == 6'd3) m_cmp = wd;
    if (io && r == 6'd4) {m_irqen, m_auto, m_en} = wd[2:0];
    if (ok && a < RAM_WORDS * 4) m_ram[a[7:2]] = wd;
  endtask

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("readdata", readdata, m_read(reset, dataadr));
      check("leds", {16'd0, leds}, {16'd0, m_leds});
      check("irq", {31'd0, irq}, {31'd0, m_irq()});
    end
  end

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd);
    memwrite  = we;
    dataadr   = a;
    writedata = wd;
  endtask

  task automatic cyc();
    @(posedge clk);
    m_edge(reset, memwrite, dataadr, writedata, switches);
    chk_en = 1'b1;
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd);
    drive(1'b1, a, wd);
    cyc();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(1'b0, A_STAT, 32'd0);
      cyc();
    end
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, a, 32'd0);
    #1;
    check(name, readdata, exp);
    cyc();
  endtask

  initial begin
    logic [31:0] a, wd;
    logic        we;
    int          sel;
    reset = 1'b0; switches = 16'd0;
    drive(1'b0, A_CMP, 32'd0);
    #1;
    check("rd_in_reset", readdata, 32'd0);
    repeat (3) cyc();
    reset = 1'b1;
    rd_check("cmp_reset", A_CMP, 32'hFFFF_FFFF);
    rd_check("ctrl_reset", A_CTRL, 32'd0);
    check("leds_reset", {16'd0, leds}, 32'd0);
    for (int i = 0; i < RAM_WORDS; i++) wr(32'(i * 4), $urandom);

    // RAM and unmapped
    wr(32'h10, 32'h1234_5678);
    rd_check("ram_rd", 32'h10, 32'h1234_5678);
    rd_check("unmapped", 32'hFFFF_FF20, 32'd0);

    // LED and switch synchroniser lag
    wr(A_LED, 32'h0000_A5A5);
    check("leds_wr", {16'd0, leds}, 32'h0000_A5A5);
    switches = 16'h00F0;
    drive(1'b0, A_SW, 32'd0);
    cyc();
    check("sw_lag1", readdata, 32'd0);
    cyc();
    check("sw_lag2", readdata, 32'h0000_00F0);

    // one-shot compare: match on the 4th tick, then HOLD
    wr(A_CNT, 32'd0);
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'd5);
    idle(16);
    check("irq_before", {31'd0, irq}, 32'd0);
    idle(1);
    check("irq_match", {31'd0, irq}, 32'd1);
    rd_check("count_hold", A_CNT, 32'd3);
    rd_check("status_match", A_STAT, 32'd1);
    idle(4);
    rd_check("count_still", A_CNT, 32'd3);
    wr(A_STAT, 32'd1);
    check("irq_w1c", {31'd0, irq}, 32'd0);

    // auto-reload; W1C on a match edge loses to the set
    wr(A_CTRL, 32'd0);
    wr(A_CNT, 32'd0);
    wr(A_CMP, 32'd1);
    wr(A_CTRL, 32'd7);
    idle(9);
    rd_check("ar_status", A_STAT, 32'd1);
    rd_check("ar_count", A_CNT, 32'd0);
    wr(A_STAT, 32'd1);
    check("ar_irq_clr", {31'd0, irq}, 32'd0);
    idle(4);
    wr(A_STAT, 32'd1);
    check("ar_set_wins", {31'd0, irq}, 32'd1);
    rd_check("ar_status2", A_STAT, 32'd1);
    rd_check("ar_count2", A_CNT, 32'd0);

    // COUNT write on a tick edge wins over the increment
    idle(1);
    wr(A_CNT, 32'h100);
    rd_check("cnt_wr_tick", A_CNT, 32'h100);
    idle(3);
    rd_check("cnt_next_tick", A_CNT, 32'h101);

    // reset mid-run
    reset = 1'b0;
    drive(1'b0, A_CMP, 32'd0);
    #1;
    check("irq_in_reset", {31'd0, irq}, 32'd0);
    cyc();
    reset = 1'b1;
    check("leds_mid_reset", {16'd0, leds}, 32'd0);
    rd_check("cmp_mid_reset", A_CMP, 32'hFFFF_FFFF);
    rd_check("cnt_mid_reset", A_CNT, 32'd0);
    rd_check("ctrl_mid_reset", A_CTRL, 32'd0);
    rd_check("stat_mid_reset", A_STAT, 32'd0);

    // misaligned write
    wr(32'h12, 32'hDEAD_BEEF);
    rd_check("misalign_ram", 32'h10, ALIGN ? 32'h1234_5678 : 32'hDEAD_BEEF);
    rd_check("misalign_stat", A_STAT, ALIGN ? 32'd2 : 32'd0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      sel = $urandom_range(0, 15);
      if (sel < 5)       a = 32'($urandom_range(0, RAM_WORDS * 4 - 1)) & 32'hFFFF_FFFC;
      else if (sel < 13) a = A_LED + 32'($urandom_range(0, 7) * 4);
      else if (sel == 13) a = $urandom;
      else               a = 32'h0000_0100 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      we = ($urandom_range(0, 2) == 0);
      wd = $urandom;
      if (a[31:8] == 24'hFF_FFFF && (a[7:2] == 6'd2 || a[7:2] == 6'd3)) wd = 32'($urandom_range(0, 6));
      if (a[31:8] == 24'hFF_FFFF && a[7:2] == 6'd4 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
      if ($urandom_range(0, 19) == 0) switches = 16'($urandom);
      reset = ($urandom_range(0, 299) != 0);
      wr(a, wd);
      memwrite = we;
      if (!we) cyc();
    end
    reset = 1'b1;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
